// File: rtl/crc_pkg.sv
// rtl/crc_pkg.sv - shared types and constants for the CRC-32/MPEG-2 frame sequencer
package crc_pkg;

    typedef enum logic [2:0] {
        IDLE,
        SHIFT,
        EMIT,
        APPEND,
        CLEAR
    } crc_seq_state_t;

    localparam logic [31:0] CRC32_MPEG2_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC32_MPEG2_POLY = 32'h04C1_1DB7;

endpackage

// File: rtl/crc32_mpeg2.sv
// rtl/crc32_mpeg2.sv - bit-serial CRC-32/MPEG-2 core, MSB-first, synchronous reset to init
module crc32_mpeg2
    import crc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        data_valid_in,
    input  logic        data_in,
    output logic [31:0] crc_out
);

    logic feedback;

    assign feedback = crc_out[31] ^ data_in;

    always_ff @(posedge clk) begin
        if (rst) begin
            crc_out <= CRC32_MPEG2_INIT;
        end else if (data_valid_in) begin
            crc_out <= {crc_out[30:0], 1'b0} ^ (feedback ? CRC32_MPEG2_POLY : 32'h0);
        end
    end

endmodule

// File: rtl/crc32_frame_sequencer.sv
// rtl/crc32_frame_sequencer.sv - byte-stream front end that serializes payload into the CRC core
// and appends the 4 CRC bytes after the last payload byte of each frame
module crc32_frame_sequencer
    import crc_pkg::*;
#(
    parameter int LEN_W      = 16,
    parameter int CLR_CYCLES = 1
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic [7:0]       s_data,
    input  logic             s_valid,
    input  logic             s_last,
    output logic             s_ready,
    output logic [7:0]       m_data,
    output logic             m_valid,
    output logic             m_last,
    input  logic             m_ready,
    output logic [31:0]      crc_value,
    output logic             crc_done,
    output logic [LEN_W-1:0] frame_len,
    output logic             busy
);

    localparam int CLR_W = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;
    localparam logic [CLR_W-1:0] CLR_LAST = CLR_W'(CLR_CYCLES - 1);

    crc_seq_state_t   state, state_next;
    logic [7:0]       byte_r;
    logic             last_r;
    logic [2:0]       bit_cnt;
    logic [1:0]       idx;
    logic [LEN_W-1:0] len_cnt;
    logic [CLR_W-1:0] clr_cnt;
    logic             clr;
    logic             shift_en;
    logic [31:0]      core_crc;
    logic [7:0]       crc_byte;

    crc32_mpeg2 u_crc (
        .clk           (clk_in),
        .rst           (rst_in | clr),
        .data_valid_in (shift_en),
        .data_in       (byte_r[bit_cnt]),
        .crc_out       (core_crc)
    );

    always_comb begin
        crc_byte = core_crc[31:24];
        case (idx)
            2'd0: crc_byte = core_crc[31:24];
            2'd1: crc_byte = core_crc[23:16];
            2'd2: crc_byte = core_crc[15:8];
            2'd3: crc_byte = core_crc[7:0];
            default: crc_byte = core_crc[31:24];
        endcase
    end

    // s_ready is gated by rst_in so it reads 0 for the whole reset window
    always_comb begin
        state_next = state;
        s_ready    = 1'b0;
        m_valid    = 1'b0;
        m_data     = 8'h00;
        m_last     = 1'b0;
        clr        = 1'b0;
        shift_en   = 1'b0;
        case (state)
            IDLE: begin
                s_ready = !rst_in;
                if (s_valid) begin
                    state_next = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                if (bit_cnt == 3'd0) begin
                    state_next = EMIT;
                end
            end
            EMIT: begin
                m_valid = 1'b1;
                m_data  = byte_r;
                if (m_ready) begin
                    state_next = last_r ? APPEND : IDLE;
                end
            end
            APPEND: begin
                m_valid = 1'b1;
                m_data  = crc_byte;
                m_last  = (idx == 2'd3);
                if (m_ready && idx == 2'd3) begin
                    state_next = CLEAR;
                end
            end
            CLEAR: begin
                clr = 1'b1;
                if (clr_cnt == CLR_LAST) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            byte_r    <= 8'h00;
            last_r    <= 1'b0;
            bit_cnt   <= 3'd0;
            idx       <= 2'd0;
            len_cnt   <= '0;
            clr_cnt   <= '0;
            crc_value <= 32'h0;
            crc_done  <= 1'b0;
            frame_len <= '0;
        end else begin
            state    <= state_next;
            crc_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (s_valid) begin
                        byte_r  <= s_data;
                        last_r  <= s_last;
                        bit_cnt <= 3'd7;
                        if (len_cnt != {LEN_W{1'b1}}) begin
                            len_cnt <= len_cnt + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    bit_cnt <= bit_cnt - 3'd1;
                end
                EMIT: begin
                    if (m_ready && last_r) begin
                        idx <= 2'd0;
                    end
                end
                APPEND: begin
                    if (m_ready) begin
                        idx <= idx + 2'd1;
                        if (idx == 2'd3) begin
                            crc_value <= core_crc;
                            frame_len <= len_cnt;
                            crc_done  <= 1'b1;
                        end
                    end
                end
                CLEAR: begin
                    len_cnt <= '0;
                    clr_cnt <= (clr_cnt == CLR_LAST) ? '0 : clr_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_crc32_frame_sequencer.sv
// tb/tb_crc32_frame_sequencer.sv - self-checking bench for crc32_frame_sequencer
module tb_crc32_frame_sequencer;

    typedef logic [7:0] u8_t;

    typedef struct {
        int          len;
        u8_t         data [0:15];
        logic [31:0] crc;
        int          stall_max;
    } vec_t;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [7:0]  s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic [7:0]  m_data;
    logic        m_valid;
    logic        m_last;
    logic        m_ready;
    logic [31:0] crc_value;
    logic        crc_done;
    logic [15:0] frame_len;
    logic        busy;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    crc32_frame_sequencer #(.LEN_W(16), .CLR_CYCLES(1)) dut (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_last    (s_last),
        .s_ready   (s_ready),
        .m_data    (m_data),
        .m_valid   (m_valid),
        .m_last    (m_last),
        .m_ready   (m_ready),
        .crc_value (crc_value),
        .crc_done  (crc_done),
        .frame_len (frame_len),
        .busy      (busy)
    );

    always #5 clk_in = ~clk_in;
    always @(posedge clk_in) cyc <= cyc + 1;

    function automatic void check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endfunction

    // Reference CRC: whole-byte XOR into the top of the register, then eight polynomial steps
    function automatic logic [31:0] ref_crc(input u8_t q[$]);
        logic [31:0] c;
        c = 32'hFFFF_FFFF;
        foreach (q[i]) begin
            c = c ^ {q[i], 24'h0};
            for (int b = 0; b < 8; b++) begin
                c = c[31] ? ((c << 1) ^ 32'h04C1_1DB7) : (c << 1);
            end
        end
        return c;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_s_ready"}, s_ready, 0);
        check({tag, "_m_valid"}, m_valid, 0);
        check({tag, "_m_last"}, m_last, 0);
        check({tag, "_m_data"}, m_data, 0);
        check({tag, "_crc_value"}, crc_value, 0);
        check({tag, "_crc_done"}, crc_done, 0);
        check({tag, "_frame_len"}, frame_len, 0);
        check({tag, "_busy"}, busy, 0);
    endtask

    task automatic run_frame(input u8_t frame[$], input logic [31:0] exp_crc,
                             input int stall_max, input int abort_at);
        u8_t  exp_q[$];
        u8_t  got_q[$];
        logic got_last[$];
        int   n_in = 0;
        int   acc_cyc = -100;
        int   stall_left;
        int   done_seen = 0;
        int   done_cyc = -1;
        int   budget = 0;
        logic prev_hold = 1'b0;
        logic prev_mv = 1'b0;
        logic [7:0] prev_data = 8'h00;
        logic prev_last = 1'b0;

        exp_q = frame;
        for (int k = 3; k >= 0; k--) exp_q.push_back(exp_crc[8*k +: 8]);
        stall_left = $urandom_range(0, stall_max);

        while (1) begin
            @(negedge clk_in);
            if (n_in < frame.size()) begin
                s_valid = 1'b1;
                s_data  = frame[n_in];
                s_last  = (n_in == frame.size() - 1);
                if (s_ready) begin
                    acc_cyc = cyc;
                    n_in++;
                end
            end else begin
                s_valid = 1'b0;
                s_last  = 1'b0;
                s_data  = 8'h00;
            end

            if (cyc > acc_cyc && cyc <= acc_cyc + 9) begin
                check("s_ready_low_after_accept", s_ready, 0);
                check("busy_after_accept", busy, 1);
            end
            if (m_valid && !prev_mv) check("m_valid_rise_latency", cyc, acc_cyc + 9);

            if (prev_hold) begin
                check("stall_m_valid", m_valid, 1);
                check("stall_m_data", m_data, prev_data);
                check("stall_m_last", m_last, prev_last);
            end

            if (m_valid) begin
                if (stall_left > 0) begin
                    m_ready = 1'b0;
                    stall_left--;
                end else begin
                    m_ready = 1'b1;
                    got_q.push_back(m_data);
                    got_last.push_back(m_last);
                    stall_left = $urandom_range(0, stall_max);
                end
            end else begin
                m_ready = 1'b0;
            end
            prev_hold = m_valid && !m_ready;
            prev_mv   = m_valid;
            prev_data = m_data;
            prev_last = m_last;

            if (crc_done) begin
                done_seen++;
                if (done_seen == 1) begin
                    check("crc_value", crc_value, exp_crc);
                    check("frame_len", frame_len, frame.size());
                    done_cyc = cyc;
                end
            end
            if (done_cyc >= 0 && cyc == done_cyc + 1) begin
                check("crc_done_one_cycle", crc_done, 0);
                break;
            end
            if (abort_at > 0 && n_in == abort_at && cyc == acc_cyc + 2) return;
            budget++;
            if (budget > 3000) begin
                check("frame_timeout", 0, 1);
                break;
            end
        end

        s_valid = 1'b0;
        s_last  = 1'b0;
        check("out_byte_count", got_q.size(), exp_q.size());
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
            check("m_data_seq", got_q[i], exp_q[i]);
            check("m_last_seq", got_last[i], (i == exp_q.size() - 1));
        end
    endtask

    vec_t vecs [0:2];
    u8_t  fq[$];
    u8_t  digits[$];

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0].len = 9; vecs[0].crc = 32'h0376_E6E7; vecs[0].stall_max = 0;
        vecs[1].len = 1; vecs[1].crc = 32'h4E08_BFB4; vecs[1].stall_max = 0;
        vecs[2].len = 9; vecs[2].crc = 32'h0376_E6E7; vecs[2].stall_max = 5;
        for (int i = 0; i < 16; i++) begin
            vecs[0].data[i] = 8'h31 + 8'(i);
            vecs[1].data[i] = 8'h00;
            vecs[2].data[i] = 8'h31 + 8'(i);
        end
        for (int i = 0; i < 9; i++) digits.push_back(8'h31 + 8'(i));

        rst_in = 1'b1; s_valid = 1'b0; s_data = 8'h00; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs("reset");
        rst_in = 1'b0;
        @(negedge clk_in);
        check("idle_s_ready", s_ready, 1);
        check("idle_busy", busy, 0);

        // Known frames, back to back without reset in between
        for (int v = 0; v < 3; v++) begin
            fq.delete();
            for (int i = 0; i < vecs[v].len; i++) fq.push_back(vecs[v].data[i]);
            run_frame(fq, vecs[v].crc, vecs[v].stall_max, 0);
        end

        // Reset while byte 3 is shifting, then a clean frame
        run_frame(digits, 32'h0376_E6E7, 0, 3);
        rst_in  = 1'b1;
        s_valid = 1'b0;
        m_ready = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        repeat (2) @(posedge clk_in);
        @(negedge clk_in);
        check_reset_outputs("mid_reset_held");
        rst_in = 1'b0;
        run_frame(digits, 32'h0376_E6E7, 0, 0);

        // Random frames against the reference model
        for (int f = 0; f < 8; f++) begin
            int len;
            fq.delete();
            len = $urandom_range(1, 12);
            for (int i = 0; i < len; i++) fq.push_back(8'($urandom));
            run_frame(fq, ref_crc(fq), $urandom_range(0, 3), 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
